led_pio_sequencer: RTL

//   Hardware pattern sequencer that drives the 10-bit LED PIO over Avalon-MM.

---
 rtl/led_seq_pkg.sv | 22 ++
 rtl/led_seq_timer.sv | 36 +++
 rtl/led_pio_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state, register map and bit positions for the LED PIO sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_ONE_SHOT = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STATUS_BUSY     = 0;
  localparam int STATUS_DONE     = 1;
  localparam int STATUS_STEP_LSB = 8;

endpackage

// File: rtl/led_seq_timer.sv
// rtl/led_seq_timer.sv - loadable step down-counter that flags the last cycle of a wait
module led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority; ticking stops at zero so an idle timer never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/led_pio_sequencer.sv
// rtl/led_pio_sequencer.sv - timed LED pattern writer to the LED PIO; optional irq via LED_SEQ_IRQ_EN
module led_pio_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int LED_W     = 10,
  parameter int PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  import led_seq_pkg::*;

  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  seq_state_e          state_q, state_d;
  logic                enable_q, enable_d;
  logic                one_shot_q, one_shot_d;
  logic                done_q, done_d;
  logic [1:0]          step_q, step_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LED_W-1:0]    pattern_q [NUM_STEPS];
  logic                wr_en, ctrl_wr, status_wr, period_wr, pattern_wr;
  logic                load, tick, expire, irq_en;
  logic [PERIOD_W-1:0] load_val;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign ctrl_wr      = wr_en & (address == ADDR_CTRL);
  assign period_wr    = wr_en & (address == ADDR_PERIOD);
  assign status_wr    = wr_en & (address == ADDR_STATUS);
  assign pattern_wr   = wr_en & address[2] & (int'(address[1:0]) < NUM_STEPS);
  assign load_val     = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign unused_wdata = ^writedata;

  assign m_address    = 2'b00;
  assign m_chipselect = (state_q == WRITE);
  assign m_write_n    = (state_q != WRITE);
  assign m_writedata  = wdata_q;

  led_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (tick),
    .expire_o   (expire)
  );

  // Register updates and sequencing; decisions use enable_d so a CPU clear stops the FSM at the same edge.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    enable_d   = enable_q;
    one_shot_d = one_shot_q;
    done_d     = done_q;
    period_d   = period_q;
    wdata_d    = '0;
    load       = 1'b0;
    tick       = 1'b0;
    if (ctrl_wr) begin
      enable_d   = writedata[CTRL_ENABLE];
      one_shot_d = writedata[CTRL_ONE_SHOT];
    end
    if (period_wr) period_d = writedata[PERIOD_W-1:0];
    if (status_wr && writedata[STATUS_DONE]) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_d) begin
          state_d = WRITE;
          wdata_d = 32'(pattern_q[step_q]);
        end
      end
      WRITE: begin
        wdata_d = wdata_q;
        if (!m_waitrequest) begin
          wdata_d = '0;
          if (!enable_d) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            state_d = WAIT;
            load    = 1'b1;
          end
        end
      end
      WAIT: begin
        tick = 1'b1;
        if (!enable_d) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (expire) begin
          if (step_q != LAST_STEP) begin
            state_d = WRITE;
            step_d  = step_q + 2'd1;
          end else if (one_shot_q) begin
            state_d  = IDLE;
            step_d   = '0;
            enable_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            state_d = WRITE;
            step_d  = '0;
          end
          if (state_d == WRITE) wdata_d = 32'(pattern_q[step_d]);
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // FSM state and control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      enable_q   <= 1'b0;
      one_shot_q <= 1'b0;
      done_q     <= 1'b0;
      period_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      enable_q   <= enable_d;
      one_shot_q <= one_shot_d;
      done_q     <= done_d;
      period_q   <= period_d;
      wdata_q    <= wdata_d;
    end
  end

  // Pattern table; a running sequence picks up new entries at their next write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern_q[i] <= '0;
    end else if (pattern_wr) begin
      pattern_q[address[1:0]] <= writedata[LED_W-1:0];
    end
  end

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_q;

  // Interrupt enable bit in CTRL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en_q <= writedata[CTRL_IRQ_EN];
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = done_q & irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Zero-wait-state read mux; unmapped addresses and unused bits read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE]   = enable_q;
        readdata[CTRL_ONE_SHOT] = one_shot_q;
        readdata[CTRL_IRQ_EN]   = irq_en;
      end
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY]                         = (state_q != IDLE);
        readdata[STATUS_DONE]                         = done_q;
        readdata[STATUS_STEP_LSB+1:STATUS_STEP_LSB]   = step_q;
      end
      default: begin
        if (address[2] && (int'(address[1:0]) < NUM_STEPS)) begin
          readdata[LED_W-1:0] = pattern_q[address[1:0]];
        end
      end
    endcase
  end

endmodule
